// File: rtl/arbitrated_mux.sv
// rtl/arbitrated_mux.sv - N-way valid/ready arbiter feeding a single-entry registered output stage
module arbitrated_mux #(
    parameter int WIDTH           = 32,
    parameter int INPUT_BUS_COUNT = 4,
    parameter bit ROUND_ROBIN     = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [INPUT_BUS_COUNT-1:0]         in_valid,
    input  logic [WIDTH-1:0]                   input_busses [INPUT_BUS_COUNT-1:0],
    output logic [INPUT_BUS_COUNT-1:0]         in_ready,
    output logic                               out_valid,
    output logic [WIDTH-1:0]                   selected_data,
    output logic [$clog2(INPUT_BUS_COUNT)-1:0] out_source,
    input  logic                               out_ready
);

    localparam int SW = $clog2(INPUT_BUS_COUNT);
    localparam logic [SW:0]   COUNT_W = (SW+1)'(INPUT_BUS_COUNT);
    localparam logic [SW-1:0] LAST_CH = SW'(INPUT_BUS_COUNT - 1);

    logic [SW-1:0] rr_pointer;
    logic [SW-1:0] scan_base;
    logic [SW-1:0] grant;
    logic [SW:0]   scan_sum;
    logic [SW-1:0] scan_idx;
    logic          found;
    logic          slot_free;
    logic          take;

    assign scan_base = ROUND_ROBIN ? rr_pointer : '0;
    assign slot_free = !out_valid || out_ready;
    assign take      = (|in_valid) && slot_free && !reset;

    // Scan from scan_base upward with an explicit wrap so non-power-of-two counts work.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < INPUT_BUS_COUNT; k++) begin
            scan_sum = {1'b0, scan_base} + k[SW:0];
            if (scan_sum >= COUNT_W) begin
                scan_sum = scan_sum - COUNT_W;
            end
            scan_idx = scan_sum[SW-1:0];
            if (!found && in_valid[scan_idx]) begin
                grant = scan_idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            selected_data <= '0;
            out_source    <= '0;
        end else if (take) begin
            out_valid     <= 1'b1;
            selected_data <= input_busses[grant];
            out_source    <= grant;
        end else if (out_valid && out_ready) begin
            out_valid     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_pointer <= '0;
        end else if (ROUND_ROBIN && take) begin
            rr_pointer <= (grant == LAST_CH) ? '0 : grant + SW'(1);
        end
    end

endmodule

// File: tb/tb_arbitrated_mux.sv
// tb/tb_arbitrated_mux.sv - directed checks of round-robin and fixed-priority arbitrated_mux instances
module tb_arbitrated_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_valid;
    logic [31:0] input_busses [3:0];
    logic        out_ready;

    logic [3:0]  rr_in_ready;
    logic        rr_out_valid;
    logic [31:0] rr_data;
    logic [1:0]  rr_source;

    logic [3:0]  fp_in_ready;
    logic        fp_out_valid;
    logic [31:0] fp_data;
    logic [1:0]  fp_source;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arbitrated_mux #(.WIDTH(32), .INPUT_BUS_COUNT(4), .ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .input_busses(input_busses),
        .in_ready(rr_in_ready), .out_valid(rr_out_valid), .selected_data(rr_data),
        .out_source(rr_source), .out_ready(out_ready)
    );

    arbitrated_mux #(.WIDTH(32), .INPUT_BUS_COUNT(4), .ROUND_ROBIN(1'b0)) fp (
        .clk(clk), .reset(reset), .in_valid(in_valid), .input_busses(input_busses),
        .in_ready(fp_in_ready), .out_valid(fp_out_valid), .selected_data(fp_data),
        .out_source(fp_source), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rr(input string tag, input logic v, input logic [31:0] d, input logic [1:0] s);
        chk({tag, "_valid"}, 64'(rr_out_valid), 64'(v));
        chk({tag, "_data"}, 64'(rr_data), 64'(d));
        chk({tag, "_src"}, 64'(rr_source), 64'(s));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) input_busses[i] = 32'hA0 + 32'(i);
        reset     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        chk("reset_in_ready", 64'(rr_in_ready), 64'h0);
        chk_rr("reset", 1'b0, 32'h0, 2'd0);

        // Round-robin rotation with all channels valid
        reset = 1'b0;
        #1;
        chk("first_grant", 64'(rr_in_ready), 64'b0001);
        tick();
        chk_rr("first_xfer", 1'b1, 32'hA0, 2'd0);
        for (int k = 1; k < 8; k++) begin
            chk("rr_ready", 64'(rr_in_ready), 64'(4'b0001 << (k % 4)));
            tick();
            chk_rr("rr_seq", 1'b1, 32'hA0 + 32'(k % 4), 2'(k % 4));
        end

        // Back-pressure: hold DEADBEEF from ch2 while ch0 waits
        input_busses[2] = 32'hDEADBEEF;
        in_valid = 4'b0100;
        tick();
        chk_rr("load_ch2", 1'b1, 32'hDEADBEEF, 2'd2);
        out_ready = 1'b0;
        in_valid = 4'b0001;
        input_busses[0] = 32'h1111_0000;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_ready", 64'(rr_in_ready), 64'h0);
            tick();
            chk_rr("stall_hold", 1'b1, 32'hDEADBEEF, 2'd2);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", 64'(rr_in_ready), 64'b0001);
        tick();
        chk_rr("release_xfer", 1'b1, 32'h1111_0000, 2'd0);

        // Pointer wrap: move pointer to 3, then ch3 beats ch0, then ch0
        input_busses[0] = 32'hA0;
        input_busses[2] = 32'hA2;
        in_valid = 4'b0100;
        tick();
        chk_rr("wrap_pre", 1'b1, 32'hA2, 2'd2);
        in_valid = 4'b1001;
        #1;
        chk("wrap_ready3", 64'(rr_in_ready), 64'b1000);
        tick();
        chk_rr("wrap_ch3", 1'b1, 32'hA3, 2'd3);
        chk("wrap_ready0", 64'(rr_in_ready), 64'b0001);
        tick();
        chk_rr("wrap_ch0", 1'b1, 32'hA0, 2'd0);

        // Reset mid-stream with pointer at 2 must return pointer to 0
        in_valid = 4'b0010;
        tick();
        chk_rr("pre_reset", 1'b1, 32'hA1, 2'd1);
        out_ready = 1'b0;
        in_valid  = 4'b0110;
        reset     = 1'b1;
        #1;
        chk("reset_mid_ready", 64'(rr_in_ready), 64'h0);
        tick();
        chk_rr("reset_mid", 1'b0, 32'h0, 2'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_reset_ready", 64'(rr_in_ready), 64'b0010);
        tick();
        chk_rr("post_reset", 1'b1, 32'hA1, 2'd1);

        // Empty: output drains, data and source hold
        in_valid = 4'b0000;
        #1;
        chk("empty_ready", 64'(rr_in_ready), 64'h0);
        tick();
        chk_rr("drain", 1'b0, 32'hA1, 2'd1);

        // Fixed priority: ch1 always beats ch3 until it drops
        reset = 1'b1;
        tick();
        chk("fp_reset_valid", 64'(fp_out_valid), 64'h0);
        reset = 1'b0;
        in_valid = 4'b1010;
        #1;
        chk("fp_ready1", 64'(fp_in_ready), 64'b0010);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fp_src1", 64'(fp_source), 64'd1);
            chk("fp_data1", 64'(fp_data), 64'hA1);
            chk("fp_hold_ready", 64'(fp_in_ready), 64'b0010);
        end
        in_valid = 4'b1000;
        #1;
        chk("fp_ready3", 64'(fp_in_ready), 64'b1000);
        tick();
        chk("fp_src3", 64'(fp_source), 64'd3);
        chk("fp_data3", 64'(fp_data), 64'hA3);
        chk("fp_valid3", 64'(fp_out_valid), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
